// File: rtl/fixed_ascii_streamer_if.sv
// Handshake/bus bundle for fixed_ascii_streamer.
// master: sample producer + byte consumer; slave: the streamer block.
interface fixed_ascii_streamer_if #(
  parameter int INT_W     = 16,
  parameter int FRAC_W    = 16,
  parameter int LABEL_LEN = 4
);
  logic [INT_W+FRAC_W-1:0] in_value;
  logic [8*LABEL_LEN-1:0]  in_label;
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              out_byte;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    ovf;

  modport master (
    output in_value, in_label, in_valid, out_ready,
    input  in_ready, out_byte, out_valid, out_last, ovf
  );

  modport slave (
    input  in_value, in_label, in_valid, out_ready,
    output in_ready, out_byte, out_valid, out_last, ovf
  );
endinterface

// File: rtl/fixed_ascii_streamer.sv
// fixed_ascii_streamer: formats a signed fixed-point sample as one labelled
// ASCII line "<label> <sign><int>.<frac>\n" and streams it byte by byte.
// Digits are extracted iteratively, one integer and one fraction digit per
// cycle, so no wide divider is needed.
// Optional feature macro: FMT_ZERO_SUPPRESS_EN (leading integer zeros shown
// as spaces; least-significant integer digit always printed).
module fixed_ascii_streamer #(
  parameter int INT_W       = 16,
  parameter int FRAC_W      = 16,
  parameter int INT_DIGITS  = 3,
  parameter int FRAC_DIGITS = 6,
  parameter int LABEL_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fixed_ascii_streamer_if.slave bus
);

  localparam int W        = INT_W + FRAC_W;
  localparam int D        = (INT_DIGITS > FRAC_DIGITS) ? INT_DIGITS : FRAC_DIGITS;
  localparam int LINE_LEN = LABEL_LEN + INT_DIGITS + FRAC_DIGITS + 4;
  localparam int CNT_W    = $clog2(D + 1);
  localparam int IDX_W    = $clog2(LINE_LEN);

  // Byte positions inside the line
  localparam int POS_SP   = LABEL_LEN;
  localparam int POS_SGN  = LABEL_LEN + 1;
  localparam int POS_INT  = LABEL_LEN + 2;
  localparam int POS_DOT  = POS_INT + INT_DIGITS;
  localparam int POS_FRAC = POS_DOT + 1;
  localparam int POS_LF   = LINE_LEN - 1;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  state_t                 state, state_nxt;
  logic [8*LABEL_LEN-1:0] label_q;
  logic                   sign_q;
  logic [INT_W-1:0]       int_q;
  logic [FRAC_W-1:0]      frac_q;
  logic [3:0]             int_dig  [INT_DIGITS];   // LS digit at index 0
  logic [3:0]             frac_dig [FRAC_DIGITS];  // MS digit at index 0
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic                   ovf_q;

  logic                   accept;
  logic                   conv_last;
  logic                   emit_hs;
  logic                   line_done;
  logic [W-1:0]           mag;
  logic                   int_active;
  logic                   frac_active;
  logic [INT_W-1:0]       int_quo;
  logic [3:0]             int_d;
  logic [INT_W-1:0]       int_after;
  logic [FRAC_W+3:0]      frac_p;
  logic [INT_DIGITS-1:0]  blank;        // MS-first: 1 = print as space
  logic [7:0]             byte_c;

  assign accept    = bus.in_valid && (state == IDLE);
  assign conv_last = (state == CONV) && (cnt == CNT_W'(D - 1));
  assign emit_hs   = (state == EMIT) && bus.out_ready;
  assign line_done = emit_hs && (idx == IDX_W'(POS_LF));

  // Magnitude fits in W unsigned bits, including the most-negative input
  assign mag = bus.in_value[W-1] ? ((~bus.in_value) + W'(1)) : bus.in_value;

  // Integer step: divide by a constant 10, once per cycle
  assign int_active = (cnt < CNT_W'(INT_DIGITS));
  assign int_quo    = int_q / INT_W'(10);
  assign int_d      = 4'(int_q % INT_W'(10));
  assign int_after  = int_active ? int_quo : int_q;

  // Fraction step: F*10, integer part is the digit, remainder carries on
  assign frac_active = (cnt < CNT_W'(FRAC_DIGITS));
  assign frac_p      = {4'd0, frac_q} * (FRAC_W + 4)'(10);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: IDLE -> CONV on accept, CONV -> EMIT after D digits,
  // EMIT -> IDLE on the LF handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CONV;
      CONV:    if (conv_last) state_nxt = EMIT;
      EMIT:    if (line_done) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: latch sample, extract digits, step the output byte index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      label_q <= '0;
      sign_q  <= 1'b0;
      int_q   <= '0;
      frac_q  <= '0;
      cnt     <= '0;
      idx     <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < INT_DIGITS; k++)  int_dig[k]  <= 4'd0;
      for (int k = 0; k < FRAC_DIGITS; k++) frac_dig[k] <= 4'd0;
    end else if (accept) begin
      label_q <= bus.in_label;
      sign_q  <= bus.in_value[W-1];
      int_q   <= mag[W-1:FRAC_W];
      frac_q  <= mag[FRAC_W-1:0];
      cnt     <= '0;
      idx     <= '0;
      ovf_q   <= 1'b0;
    end else if (state == CONV) begin
      cnt <= cnt + CNT_W'(1);
      if (int_active) begin
        int_q <= int_quo;
        for (int k = 0; k < INT_DIGITS; k++)
          if (cnt == CNT_W'(k)) int_dig[k] <= int_d;
      end
      if (frac_active) begin
        frac_q <= frac_p[FRAC_W-1:0];
        for (int k = 0; k < FRAC_DIGITS; k++)
          if (cnt == CNT_W'(k)) frac_dig[k] <= frac_p[FRAC_W+3:FRAC_W];
      end
      // Anything left after the last integer digit did not fit
      if (conv_last) ovf_q <= (int_after != '0);
    end else if (emit_hs) begin
      idx <= line_done ? '0 : idx + IDX_W'(1);
    end
  end

`ifdef FMT_ZERO_SUPPRESS_EN
  // Blank a run of leading zero digits, never the least-significant one
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = '0;
    for (int p = 0; p < INT_DIGITS - 1; p++) begin
      run      = run && (int_dig[INT_DIGITS-1-p] == 4'd0);
      blank[p] = run;
    end
  end
`else
  assign blank = '0;
`endif

  // Character for the current byte index; 0x00 outside EMIT
  always_comb begin
    byte_c = 8'h00;
    if (state == EMIT) begin
      for (int k = 0; k < LABEL_LEN; k++)
        if (idx == IDX_W'(k)) byte_c = label_q[8*(LABEL_LEN-1-k) +: 8];
      if (idx == IDX_W'(POS_SP))  byte_c = 8'h20;
      if (idx == IDX_W'(POS_SGN)) byte_c = sign_q ? 8'h2D : 8'h2B;
      for (int p = 0; p < INT_DIGITS; p++)
        if (idx == IDX_W'(POS_INT + p))
          byte_c = blank[p] ? 8'h20 : {4'h3, int_dig[INT_DIGITS-1-p]};
      if (idx == IDX_W'(POS_DOT)) byte_c = 8'h2E;
      for (int p = 0; p < FRAC_DIGITS; p++)
        if (idx == IDX_W'(POS_FRAC + p)) byte_c = {4'h3, frac_dig[p]};
      if (idx == IDX_W'(POS_LF))  byte_c = 8'h0A;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == EMIT);
  assign bus.out_byte  = byte_c;
  assign bus.out_last  = (state == EMIT) && (idx == IDX_W'(POS_LF));
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_ascii_streamer.sv
// Directed bench for fixed_ascii_streamer with default parameters.
module tb_fixed_ascii_streamer;
  typedef logic [135:0] val_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fixed_ascii_streamer_if #(.INT_W(16), .FRAC_W(16), .LABEL_LEN(4)) bus ();

  fixed_ascii_streamer #(
    .INT_W(16), .FRAC_W(16), .INT_DIGITS(3), .FRAC_DIGITS(6), .LABEL_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input val_t obs, input val_t exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef FMT_ZERO_SUPPRESS_EN
  localparam val_t E1 = "TEMP +  1.500000\n";
  localparam val_t E2 = "TEMP -  1.000000\n";
  localparam val_t E4 = "TEMP +  0.000015\n";
  localparam val_t E6 = "TEMP +  0.000000\n";
  localparam val_t E7 = "VOLT -  1.250000\n";
  localparam val_t E8 = "VOLT +  1.500000\n";
`else
  localparam val_t E1 = "TEMP +001.500000\n";
  localparam val_t E2 = "TEMP -001.000000\n";
  localparam val_t E4 = "TEMP +000.000015\n";
  localparam val_t E6 = "TEMP +000.000000\n";
  localparam val_t E7 = "VOLT -001.250000\n";
  localparam val_t E8 = "VOLT +001.500000\n";
`endif
  localparam val_t E3 = "TEMP -768.000000\n";
  localparam val_t E5 = "TEMP +234.000000\n";

  // One line: offer sample, check latency, collect 17 bytes under the given
  // out_ready mode (0: always ready, 1: 1,0,0,1 then random). Optionally
  // keeps in_valid high with the next sample, or pulses reset after
  // abort_n handshakes. Called and returns at a falling edge.
  task automatic do_line(input string tag, input logic [31:0] value,
                         input logic [31:0] label, input int mode,
                         input logic hold, input logic [31:0] nxt_value,
                         input val_t exp_line, input logic exp_ovf,
                         input int abort_n);
    val_t       line = '0;
    int         n = 0, lat = 0, guard = 0, pat = 0;
    int         stab_err = 0, rdy_err = 0, last_err = 0;
    logic       stalled = 1'b0;
    logic [7:0] sb = 8'h00;
    logic [7:0] b;
    logic       r;

    bus.in_value = value;
    bus.in_label = label;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    chk({tag, "_acc_timeout"}, val_t'(guard >= 100), val_t'(0));
    @(posedge clk); #1;
    chk({tag, "_ovf_clr"}, val_t'(bus.ovf), val_t'(0));
    if (hold) bus.in_value = nxt_value;
    else      bus.in_valid = 1'b0;

    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.out_valid) begin lat = k; break; end
    end
    chk({tag, "_lat"}, val_t'(lat), val_t'(6));

    guard = 0;
    while (n < 17 && guard < 400) begin
      if (!bus.out_valid) break;
      b = bus.out_byte;
      if (stalled && b !== sb) stab_err++;
      if (bus.in_ready) rdy_err++;
      if (mode == 0)    r = 1'b1;
      else if (pat < 4) r = (pat == 0 || pat == 3);
      else              r = 1'($urandom_range(0, 1));
      pat++;
      bus.out_ready = r;
      if (r) begin
        line = {line[127:0], b};
        if (bus.out_last !== (n == 16)) last_err++;
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        sb      = b;
      end
      @(posedge clk); @(negedge clk); guard++;
      if (abort_n > 0 && n == abort_n) begin
        bus.out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, val_t'(bus.out_valid), val_t'(0));
        chk({tag, "_rst_ready"}, val_t'(bus.in_ready), val_t'(1));
        chk({tag, "_rst_last"},  val_t'(bus.out_last), val_t'(0));
        chk({tag, "_rst_byte"},  val_t'(bus.out_byte), val_t'(0));
        chk({tag, "_rst_ovf"},   val_t'(bus.ovf), val_t'(0));
        return;
      end
    end

    chk({tag, "_count"}, val_t'(n), val_t'(17));
    chk({tag, "_line"},  line, exp_line);
    chk({tag, "_stable"}, val_t'(stab_err), val_t'(0));
    chk({tag, "_busy"},   val_t'(rdy_err), val_t'(0));
    chk({tag, "_last"},   val_t'(last_err), val_t'(0));
    // Bubble cycle: back in IDLE, ovf held
    chk({tag, "_drop"},  val_t'(bus.out_valid), val_t'(0));
    chk({tag, "_idle"},  val_t'(bus.in_ready), val_t'(1));
    chk({tag, "_ovf"},   val_t'(bus.ovf), val_t'(exp_ovf));
  endtask

  initial begin
    bus.in_value  = '0;
    bus.in_label  = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_ready", val_t'(bus.in_ready),  val_t'(1));
    chk("rst_valid", val_t'(bus.out_valid), val_t'(0));
    chk("rst_byte",  val_t'(bus.out_byte),  val_t'(0));
    chk("rst_last",  val_t'(bus.out_last),  val_t'(0));
    chk("rst_ovf",   val_t'(bus.ovf),       val_t'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_line("pos1p5",  32'h0001_8000, "TEMP", 0, 1'b0, '0, E1, 1'b0, 0);
    do_line("neg1",    32'hFFFF_0000, "TEMP", 0, 1'b0, '0, E2, 1'b0, 0);
    do_line("mostneg", 32'h8000_0000, "TEMP", 0, 1'b0, '0, E3, 1'b1, 0);
    do_line("lsb",     32'h0000_0001, "TEMP", 0, 1'b0, '0, E4, 1'b0, 0);
    do_line("ovf1234", 32'h04D2_0000, "TEMP", 0, 1'b0, '0, E5, 1'b1, 0);
    do_line("zero",    32'h0000_0000, "TEMP", 0, 1'b0, '0, E6, 1'b0, 0);

    // Backpressure with in_valid held across both lines
    do_line("bp_a", 32'hFFFE_C000, "VOLT", 1, 1'b1, 32'h0001_8000, E7, 1'b0, 0);
    do_line("bp_b", 32'h0001_8000, "VOLT", 1, 1'b0, '0, E8, 1'b0, 0);

    // Reset in the middle of a line, then a clean line
    do_line("abort", 32'h04D2_0000, "TEMP", 0, 1'b0, '0, E5, 1'b1, 5);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_line("after_rst", 32'h0000_0001, "TEMP", 0, 1'b0, '0, E4, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/fixed_ascii_streamer.md
Name: fixed_ascii_streamer

Overview:
- Converts a signed fixed-point sample into one labelled ASCII text line and streams it out one byte per handshake, for the UART/text-console path.
- Generalises the Q16.16 formatter: parametrised integer/fraction widths, digit counts and label length.
- Uses iterative digit extraction (one digit per cycle) instead of wide dividers.
- Adds ready/valid flow control on both sides and an integer-overflow flag.

Parameters:
- INT_W, 16, integer bits of input (two's complement, sign included).
- FRAC_W, 16, fraction bits of input.
- INT_DIGITS, 3, decimal integer digits printed (>=1).
- FRAC_DIGITS, 6, decimal fraction digits printed (>=1).
- LABEL_LEN, 4, label characters printed (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- in_value  in  INT_W+FRAC_W  signed fixed-point sample.
- in_label  in  8*LABEL_LEN  label; first character in MSByte.
- in_valid  in  1  sample/label present.
- in_ready  out  1  block can accept a sample.
- out_byte  out  8  ASCII character.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  downstream accepts out_byte.
- out_last  out  1  marks the final byte (LF) of the line.
- ovf  out  1  integer magnitude did not fit in INT_DIGITS for the current line.

Behaviour:
- Line layout, LINE_LEN = LABEL_LEN + INT_DIGITS + FRAC_DIGITS + 4 bytes:
  - label bytes, then 0x20, then sign '+' or '-';
  - INT_DIGITS integer digits, most significant first;
  - '.', then FRAC_DIGITS fraction digits;
  - 0x0A.
- Reset state (async, while rst=0): state IDLE, out_valid=0, out_last=0, out_byte=0x00, ovf=0, all internal digit/counter registers cleared.
- in_ready = (state==IDLE), combinational from the state register; it reads 1 during reset.
- IDLE -> CONV on the accept edge (in_valid & in_ready):
  - latch label, sign = MSB, and magnitude = two's-complement negation if negative, held in INT_W+FRAC_W unsigned bits;
  - most-negative input therefore gives magnitude 2^(INT_W-1), which is legal.
- CONV lasts D = max(INT_DIGITS, FRAC_DIGITS) cycles. Integer and fraction extraction run in parallel:
  - Integer: per cycle, digit = I mod 10, I = I / 10, stored LS digit first. Stops after INT_DIGITS digits.
  - Fraction: per cycle, P = F*10; digit = P >> FRAC_W; F = P mod 2^FRAC_W. Stops after FRAC_DIGITS digits. Result is truncation: floor(frac * 10^FRAC_DIGITS / 2^FRAC_W), never rounded.
  - ovf is set if I != 0 after INT_DIGITS integer digits; the printed integer is the low INT_DIGITS decimal digits.
- CONV -> EMIT on the D-th CONV edge; out_valid=1 with the first label byte after that edge.
  - Latency: out_valid is high after clock edge D, counting the accept edge as edge 0 (edge 6 with defaults).
- EMIT:
  - A byte index advances only on out_valid & out_ready.
  - out_byte and out_last stay stable while stalled.
  - out_last=1 only with the LF byte.
  - On the LF handshake: go to IDLE and drop out_valid the same edge.
  - A new sample can be accepted on the following edge, giving one bubble cycle between lines.
- in_valid while not IDLE is ignored (not latched).
- ovf is updated at CONV->EMIT, stays valid through EMIT and IDLE, and clears on the next accept.
- Reset asserted mid-CONV or mid-EMIT aborts the line immediately; partial lines are never resumed.

Optional Feature:
- Macro: FMT_ZERO_SUPPRESS_EN.
- Defined: leading integer zeros are printed as 0x20. The least-significant integer digit is always printed. The sign keeps its position. Line length is unchanged.
- Undefined: all INT_DIGITS digits are printed, including leading zeros.

Test Plan:
- 0x0001_8000, label "TEMP", out_ready=1 -> bytes "TEMP +001.500000\n" (17 bytes), out_last only on byte 17, ovf=0, first out_valid at edge 6. With FMT_ZERO_SUPPRESS_EN -> "TEMP +  1.500000\n".
- 0xFFFF_0000 -> "TEMP -001.000000\n". Also 0x8000_0000 -> "-768.000000" (32768 mod 1000) with ovf=1.
- 0x0000_0001 -> "+000.000015", confirming truncation (floor(10^6/65536) = 15).
- 0x04D2_0000 (1234) -> "+234.000000", ovf=1. The next sample 0x0000_0000 -> "+000.000000", ovf=0.
- Backpressure: out_ready pattern 1,0,0,1,... random and in_valid held high throughout -> no byte dropped or duplicated, out_byte stable during stalls, in_ready=0 until the LF handshake, second line starts after one bubble.
- rst pulsed low after the 5th byte handshake -> out_valid=0 asynchronously, in_ready=1. The next accepted sample emits from the first label byte with correct digits.
